// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU output packer and its word FIFO.
package ppu_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_ADDR_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } ppu_state_e;

endpackage

// File: rtl/ppu_out_packer_if.sv
// Job control, PPU byte stream and GLB word-write port of the output packer.
interface ppu_out_packer_if
   import ppu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) ();

   // Both streams use strict valid/ready: a transfer happens on a rising edge
   // where valid (in_valid / glb_we) and ready (in_ready / glb_ready) are both
   // high; a producer holding valid keeps its payload stable until it transfers.
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  byte_count;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              glb_we;
   logic [ADDR_W-1:0] glb_addr;
   logic [31:0]       glb_wdata;
   logic              glb_ready;
   logic              busy;
   logic              done;

   modport slave (
      input  start, base_addr, byte_count, in_valid, in_data, glb_ready,
      output in_ready, glb_we, glb_addr, glb_wdata, busy, done
   );

   modport master (
      output start, base_addr, byte_count, in_valid, in_data, glb_ready,
      input  in_ready, glb_we, glb_addr, glb_wdata, busy, done
   );

endinterface

// File: rtl/ppu_word_fifo.sv
// Synchronous word FIFO; pointers carry an extra wrap bit to tell full from empty.
module ppu_word_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]   mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/ppu_out_packer.sv
// Packs PPU int8 results little-endian into 32-bit words and writes them to the GLB.
module ppu_out_packer
   import ppu_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   ppu_out_packer_if.slave bus,
   output ppu_state_e      state_dbg
);

   ppu_state_e        state;
   logic [ADDR_W-1:0] cfg_base;
   logic [CNT_W-1:0]  cfg_count;
   logic [CNT_W-1:0]  byte_cnt;
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       pack_q;
   logic [31:0]       pack_word;
   logic              busy_q;
   logic              done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [31:0]       fifo_head;

   logic [LANE_W-1:0] lane;
   logic              in_ready_w;
   logic              accept;
   logic              last_byte;
   logic              push;
   logic              pop;

   assign lane       = byte_cnt[LANE_W-1:0];
   assign in_ready_w = (state == ST_PACK) && !fifo_full;
   assign accept     = bus.in_valid && in_ready_w;
   assign last_byte  = (byte_cnt == cfg_count - CNT_W'(1));
   assign push       = accept && ((lane == LANE_W'(BYTES_PER_WORD - 1)) || last_byte);
   assign pop        = !fifo_empty && bus.glb_ready;

   // Word being assembled, with the incoming byte dropped into its lane;
   // lanes above it are still zero from the previous clear.
   always_comb begin
      pack_word = pack_q;
      pack_word[{lane, 3'b000} +: 8] = bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cfg_base  <= '0;
         cfg_count <= '0;
         byte_cnt  <= '0;
         word_idx  <= '0;
         pack_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (pop) word_idx <= word_idx + ADDR_W'(1);

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  cfg_base  <= bus.base_addr;
                  cfg_count <= bus.byte_count;
                  byte_cnt  <= '0;
                  word_idx  <= '0;
                  pack_q    <= '0;
                  busy_q    <= 1'b1;
                  if (bus.byte_count == '0) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= ST_PACK;
                  end
               end
            end

            ST_PACK: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  pack_q   <= push ? 32'h0 : pack_word;
                  if (last_byte) state <= ST_FLUSH;
               end
            end

            // Wait for every buffered word to be committed before signalling done.
            ST_FLUSH: begin
               if (fifo_empty) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end

            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   ppu_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (pack_word),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign bus.in_ready  = in_ready_w;
   assign bus.glb_we    = !fifo_empty;
   assign bus.glb_addr  = cfg_base + word_idx;
   assign bus.glb_wdata = fifo_empty ? 32'h0 : fifo_head;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_ppu_out_packer.sv
// Directed bench for ppu_out_packer: byte feeder, GLB sink with backpressure, word scoreboard.
module tb_ppu_out_packer;
   import ppu_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppu_out_packer_if #(.ADDR_W(32), .CNT_W(16)) bus ();
   ppu_state_e state_dbg;

   ppu_out_packer #(
      .ADDR_W     (32),
      .CNT_W      (16),
      .FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   int cyc             = 0;
   int acc_cnt         = 0;
   int done_cnt        = 0;
   int done_cyc        = 0;
   int last_commit_cyc = 0;
   int last_start_cyc  = 0;
   int hold            = 0;
   bit feed_en         = 1'b0;

   logic [7:0]  src_q[$];
   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];

   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr  = '0;
   logic [31:0] prev_data  = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Feeder, GLB sink and monitor; inputs change at negedge for the next posedge.
   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.glb_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         bus.glb_ready = (hold == 0);
         if (hold > 0) hold--;
         bus.in_valid = feed_en && (src_q.size() > 0);
         if (bus.in_valid) bus.in_data = src_q[0];
         else              bus.in_data = 8'h00;
         if (!rst) begin
            if (prev_stall) begin
               check("hold_addr", bus.glb_addr, prev_addr);
               check("hold_data", bus.glb_wdata, prev_data);
            end
            if (bus.glb_we && bus.glb_ready) begin
               obs_q.push_back({bus.glb_addr, bus.glb_wdata});
               last_commit_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
               acc_cnt++;
               void'(src_q.pop_front());
            end
            if (bus.done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (bus.start) last_start_cyc = cyc;
         end
         prev_stall = !rst && bus.glb_we && !bus.glb_ready;
         prev_addr  = bus.glb_addr;
         prev_data  = bus.glb_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.byte_count = cnt;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) src_q.push_back(first + 8'(i));
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
   endtask

   // scoreboard: compare committed words against the expected queue
   task automatic check_words(input string tag);
      check({tag, "_nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check(tag, obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int acc0;
      int d0;
      int n;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.byte_count = '0;

      // reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_glb_we", bus.glb_we, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_addr", bus.glb_addr, 0);
      check("rst_wdata", bus.glb_wdata, 0);
      check("rst_state", state_dbg, ST_IDLE);
      rst = 1'b0;
      tick();

      // full words, no backpressure
      load(8'h01, 8);
      feed_en = 1'b1;
      exp_q.push_back({32'h0000_0100, 32'h0403_0201});
      exp_q.push_back({32'h0000_0101, 32'h0807_0605});
      start_job(32'h100, 16'd8);
      wait_done(100);
      check("t1_busy_after", bus.busy, 0);
      check("t1_done_after", bus.done, 0);
      check("t1_done_lat", 64'(done_cyc - last_commit_cyc), 64'd2);
      check_words("t1_word");

      // partial tail, extra byte refused
      acc0 = acc_cnt;
      load(8'hA1, 7);
      exp_q.push_back({32'h0000_0200, 32'hA4A3_A2A1});
      exp_q.push_back({32'h0000_0201, 32'h0000_A6A5});
      start_job(32'h200, 16'd6);
      wait_done(100);
      check_words("t2_word");
      check("t2_accepted", 64'(acc_cnt - acc0), 64'd6);
      check("t2_left", 64'(src_q.size()), 64'd1);
      repeat (3) tick();
      check("t2_idle_accept", 64'(acc_cnt - acc0), 64'd6);
      feed_en = 1'b0;
      src_q.delete();
      tick();

      // backpressure
      acc0 = acc_cnt;
      load(8'h10, 16);
      feed_en = 1'b1;
      hold = 12;
      start_job(32'h300, 16'd16);
      repeat (10) tick();
      check("t3_accepted_held", 64'(acc_cnt - acc0), 64'd8);
      check("t3_in_ready_held", bus.in_ready, 0);
      check("t3_glb_we_held", bus.glb_we, 1);
      exp_q.push_back({32'h0000_0300, 32'h1312_1110});
      exp_q.push_back({32'h0000_0301, 32'h1716_1514});
      exp_q.push_back({32'h0000_0302, 32'h1B1A_1918});
      exp_q.push_back({32'h0000_0303, 32'h1F1E_1D1C});
      wait_done(200);
      check_words("t3_word");
      check("t3_accepted", 64'(acc_cnt - acc0), 64'd16);

      // zero-length job
      start_job(32'h400, 16'd0);
      wait_done(10);
      check("t4_zero_lat", 64'(done_cyc - last_start_cyc), 64'd1);
      check_words("t4_zero");

      // start while busy is ignored
      d0 = done_cnt;
      load(8'h31, 8);
      exp_q.push_back({32'h0000_0500, 32'h3433_3231});
      exp_q.push_back({32'h0000_0501, 32'h3837_3635});
      start_job(32'h500, 16'd8);
      repeat (3) tick();
      start_job(32'h900, 16'd4);
      wait_done(100);
      repeat (5) tick();
      check_words("t4_restart");
      check("t4_done_once", 64'(done_cnt - d0), 64'd1);

      // reset mid-job
      acc0 = acc_cnt;
      load(8'h41, 12);
      start_job(32'h600, 16'd12);
      n = 0;
      while ((acc_cnt - acc0) < 5 && n < 50) begin
         tick();
         n++;
      end
      check("t5_five_bytes", 64'(acc_cnt - acc0), 64'd5);
      rst = 1'b1;
      feed_en = 1'b0;
      tick();
      check("t5_glb_we", bus.glb_we, 0);
      check("t5_in_ready", bus.in_ready, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_state", state_dbg, ST_IDLE);
      d0 = done_cnt;
      rst = 1'b0;
      src_q.delete();
      obs_q.delete();
      repeat (6) tick();
      check("t5_no_done", 64'(done_cnt - d0), 64'd0);
      check("t5_no_write", 64'(obs_q.size()), 64'd0);
      load(8'h51, 4);
      feed_en = 1'b1;
      exp_q.push_back({32'h0000_0700, 32'h5453_5251});
      start_job(32'h700, 16'd4);
      wait_done(100);
      check_words("t5_word");

      // address wrap
      load(8'h61, 8);
      exp_q.push_back({32'hFFFF_FFFF, 32'h6463_6261});
      exp_q.push_back({32'h0000_0000, 32'h6867_6665});
      start_job(32'hFFFF_FFFF, 16'd8);
      wait_done(100);
      check_words("t6_wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ppu_out_packer.md
Name: ppu_out_packer

Overview:
- Sits directly downstream of the post-processing unit (PPU).
- Accepts the PPU's stream of int8 results (post-quant, optional maxpool, optional ReLU) one byte per handshake.
- Packs four bytes little-endian into a 32-bit word, buffers words in a small FIFO and writes them to the global buffer (GLB) at consecutive word addresses.
- Runs one job per start pulse, sized by a byte count; pads the final partial word with zeros and pulses done once all words are committed.

Parameters:
- ADDR_W, 32, GLB word-address width.
- CNT_W, 16, width of byte-count and internal counters.
- FIFO_DEPTH, 2, packed-word FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job start; sampled only in IDLE.
- base_addr  in  ADDR_W  GLB word address of the first output word; latched on start.
- byte_count  in  CNT_W  number of int8 results in the job; latched on start.
- in_valid  in  1  PPU byte valid.
- in_data  in  8  PPU output byte (data_out of the PPU).
- in_ready  out  1  packer accepts the byte this cycle.
- glb_we  out  1  write request; high while the FIFO is non-empty.
- glb_addr  out  ADDR_W  word address of the head word.
- glb_wdata  out  32  head word.
- glb_ready  in  1  GLB accepts the write this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0, FIFO emptied, counters 0, state IDLE. Reset mid-job aborts the job: no further writes and no done.
- FSM states: IDLE, PACK, FLUSH, DONE.
  - IDLE -> PACK on start with byte_count≠0.
  - IDLE -> DONE on start with byte_count==0 (done pulses the next cycle, no writes).
  - PACK -> FLUSH the cycle after the last byte's word is pushed.
  - FLUSH -> DONE when the FIFO is empty.
  - DONE -> IDLE after exactly one cycle, with done=1 for that cycle.
- start outside IDLE is ignored; latched config is unchanged.
- in_ready = (state==PACK) && !fifo_full. A byte is accepted when in_valid && in_ready.
- Lane = bytes_accepted[1:0]. Lane 0 lands in wdata[7:0], lane 3 in wdata[31:24].
- Push rule: on accepting a byte in lane 3, or the job's last byte, the assembled word is pushed that same edge. Unfilled upper lanes are 0, and the pack register clears.
- Latency: word pushed on the edge at the end of cycle N (the cycle its final byte is accepted) → glb_we=1 with that word in cycle N+1.
- Write handshake:
  - Commit when glb_we && glb_ready.
  - Unchanged rule: while glb_we && !glb_ready, glb_addr and glb_wdata hold stable.
  - The word index increments per commit; glb_addr = base_addr + word_index, with modulo-2^ADDR_W wrap.
- Push and pop in the same cycle are allowed when the FIFO is neither empty nor full; occupancy is then unchanged. No push ever occurs when full.
- Word count = ceil(byte_count/4). done rises exactly one cycle after the last commit: FLUSH sees the FIFO empty in that cycle, DONE follows.
- in_valid outside PACK is ignored and nothing is stored; in_ready is 0 there.
- The byte counter never exceeds byte_count; extra PPU bytes are not accepted.

Decomposition:
- ppu_pkg holds:
  - the state enum (IDLE/PACK/FLUSH/DONE);
  - BYTES_PER_WORD=4;
  - lane-index width;
  - the default CNT_W/ADDR_W constants.
- Sub-module ppu_word_fifo: synchronous 32-bit FIFO, FIFO_DEPTH entries, push/pop/full/empty/head. Pointers carry one extra wrap bit for full/empty.
- FSM, lane packing and address counter stay in ppu_out_packer.

Test Plan:
- Full words, no backpressure: base_addr=0x100, byte_count=8, bytes 0x01..0x08 back-to-back, glb_ready=1 → writes 0x04030201@0x100 then 0x08070605@0x101; done one cycle after the second commit; busy falls with done.
- Partial tail: byte_count=6, bytes 0xA1..0xA6 → 0xA4A3A2A1@base, then 0x0000A6A5@base+1; 6 bytes accepted; a 7th in_valid byte is not accepted.
- Backpressure: byte_count=16, glb_ready=0 for 12 cycles → exactly 8 bytes accepted, then in_ready=0; glb_addr/glb_wdata stable throughout; after release all 4 words are written in order at base..base+3.
- Zero-length and start-while-busy: byte_count=0 → done the cycle after start, glb_we never 1. A second start mid-job with a different base → ignored; addresses follow the first base.
- Reset mid-job: rst=1 after 5 bytes → next cycle glb_we=0, in_ready=0, busy=0; no done. A new job of 4 bytes then writes a single correct word at its own base.
- Address wrap: base_addr=0xFFFFFFFF, byte_count=8 → words at 0xFFFFFFFF and 0x00000000.
